// File: rtl/rdat_line_queue.sv
`default_nettype none
// ============================================================================
// Module      : rdat_line_queue
// Description : Tags completed AXI read lines with their issue-time ARID and
//               buffers them in a FWFT queue toward the consumer. The optional
//               sticky error flags are enabled with macro RDQ_ERR_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rdat_line_queue #(
    parameter int PTR_W          = 2,
    parameter int ALMOST_FULL_TH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         next_rrq,
    input  logic [3:0]   next_rid,
    input  logic [127:0] rdat_m_data,
    input  logic         rdat_m_valid,
    output logic         rqfull_1,
    output logic         q_valid,
    input  logic         q_ready,
    output logic [127:0] q_data,
    output logic [3:0]   q_id,
    output logic         rdq_idle
`ifdef RDQ_ERR_CHK_EN
    ,
    output logic [1:0]   rdq_err
`endif
);
    localparam int             c_DEPTH = 1 << PTR_W;
    localparam int             c_CW    = PTR_W + 1;
    localparam logic [PTR_W:0] c_FULL  = c_CW'(c_DEPTH);

    logic [3:0]       r_id_mem [c_DEPTH];
    logic [PTR_W-1:0] r_id_wptr;
    logic [PTR_W-1:0] r_id_rptr;
    logic [PTR_W:0]   r_id_cnt;

    logic [131:0]     r_d_mem [c_DEPTH];
    logic [PTR_W-1:0] r_d_wptr;
    logic [PTR_W-1:0] r_d_rptr;
    logic [PTR_W:0]   r_d_cnt;

    logic         w_id_empty;
    logic         w_id_full;
    logic         w_id_pop;
    logic         w_id_bypass;
    logic         w_id_push;
    logic [3:0]   w_line_id;
    logic         w_q_pop;
    logic         w_d_full;
    logic         w_d_wr;
    logic [131:0] w_head;
    logic [31:0]  w_used;

    assign w_id_empty  = (r_id_cnt == '0);
    assign w_id_full   = (r_id_cnt == c_FULL);
    assign w_id_pop    = rdat_m_valid && !w_id_empty;
    // An ID issued in the same cycle its line returns never touches storage.
    assign w_id_bypass = rdat_m_valid && w_id_empty && next_rrq;
    assign w_id_push   = next_rrq && !w_id_bypass && (!w_id_full || w_id_pop);
    assign w_line_id   = !w_id_empty ? r_id_mem[r_id_rptr]
                                     : (next_rrq ? next_rid : 4'd0);

    assign w_q_pop  = q_valid && q_ready;
    assign w_d_full = (r_d_cnt == c_FULL);
    assign w_d_wr   = rdat_m_valid && (!w_d_full || w_q_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id_wptr <= '0;
            r_id_rptr <= '0;
            r_id_cnt  <= '0;
            r_d_wptr  <= '0;
            r_d_rptr  <= '0;
            r_d_cnt   <= '0;
        end else begin
            if (w_id_push) r_id_wptr <= r_id_wptr + PTR_W'(1);
            if (w_id_pop)  r_id_rptr <= r_id_rptr + PTR_W'(1);
            case ({w_id_push, w_id_pop})
                2'b10:   r_id_cnt <= r_id_cnt + c_CW'(1);
                2'b01:   r_id_cnt <= r_id_cnt - c_CW'(1);
                default: r_id_cnt <= r_id_cnt;
            endcase

            if (w_d_wr)  r_d_wptr <= r_d_wptr + PTR_W'(1);
            if (w_q_pop) r_d_rptr <= r_d_rptr + PTR_W'(1);
            case ({w_d_wr, w_q_pop})
                2'b10:   r_d_cnt <= r_d_cnt + c_CW'(1);
                2'b01:   r_d_cnt <= r_d_cnt - c_CW'(1);
                default: r_d_cnt <= r_d_cnt;
            endcase
        end
    end

    // When full with a same-cycle pop, wptr equals rptr: the head is read out
    // this cycle before being overwritten at the edge.
    always_ff @(posedge clk) begin
        if (w_id_push) r_id_mem[r_id_wptr] <= next_rid;
        if (w_d_wr)    r_d_mem[r_d_wptr]   <= {w_line_id, rdat_m_data};
    end

    assign w_head   = r_d_mem[r_d_rptr];
    assign q_id     = w_head[131:128];
    assign q_data   = w_head[127:0];
    assign q_valid  = (r_d_cnt != '0);
    assign rdq_idle = (r_id_cnt == '0) && (r_d_cnt == '0);

    assign w_used   = 32'(r_d_cnt) + 32'(r_id_cnt);
    assign rqfull_1 = (w_used + 32'(ALMOST_FULL_TH)) >= 32'(c_DEPTH);

`ifdef RDQ_ERR_CHK_EN
    logic [1:0] r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 2'b00;
        end else begin
            if (rdat_m_valid && w_d_full && !w_q_pop)     r_err[0] <= 1'b1;
            if (rdat_m_valid && w_id_empty && !next_rrq) r_err[1] <= 1'b1;
        end
    end

    assign rdq_err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rdat_line_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rdat_line_queue
// Description : Directed vector bench for rdat_line_queue (DEPTH=4, TH=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rdat_line_queue;

    logic         clk;
    logic         rst_n;
    logic         next_rrq;
    logic [3:0]   next_rid;
    logic [127:0] rdat_m_data;
    logic         rdat_m_valid;
    logic         rqfull_1;
    logic         q_valid;
    logic         q_ready;
    logic [127:0] q_data;
    logic [3:0]   q_id;
    logic         rdq_idle;
`ifdef RDQ_ERR_CHK_EN
    logic [1:0]   rdq_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    rdat_line_queue #(.PTR_W(2), .ALMOST_FULL_TH(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .next_rrq     (next_rrq),
        .next_rid     (next_rid),
        .rdat_m_data  (rdat_m_data),
        .rdat_m_valid (rdat_m_valid),
        .rqfull_1     (rqfull_1),
        .q_valid      (q_valid),
        .q_ready      (q_ready),
        .q_data       (q_data),
        .q_id         (q_id),
        .rdq_idle     (rdq_idle)
`ifdef RDQ_ERR_CHK_EN
        ,
        .rdq_err      (rdq_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rrq;
        logic [3:0] rid;
        logic       mv;
        logic [7:0] dtag;
        logic       rdy;
        logic       e_valid;
        logic [3:0] e_id;
        logic [7:0] e_dtag;
        logic       e_full;
        logic       e_idle;
    } vec_t;

    vec_t vq[$];

    function automatic logic [127:0] ln(input logic [7:0] t);
        return {4{24'hC0FFEE, t}};
    endfunction

    function automatic vec_t mk(input logic rst, input logic rrq, input logic [3:0] rid,
                                input logic mv, input logic [7:0] dtag, input logic rdy,
                                input logic ev, input logic [3:0] eid, input logic [7:0] edt,
                                input logic ef, input logic ei);
        vec_t v;
        v.rst = rst; v.rrq = rrq; v.rid = rid; v.mv = mv; v.dtag = dtag; v.rdy = rdy;
        v.e_valid = ev; v.e_id = eid; v.e_dtag = edt; v.e_full = ef; v.e_idle = ei;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the clock edge.
    task automatic step(input logic rst, input logic rrq, input logic [3:0] rid,
                        input logic mv, input logic [7:0] dtag, input logic rdy);
        rst_n        = rst;
        next_rrq     = rrq;
        next_rid     = rid;
        rdat_m_valid = mv;
        rdat_m_data  = ln(dtag);
        q_ready      = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; next_rrq = 1'b0; next_rid = '0;
        rdat_m_valid = 1'b0; rdat_m_data = '0; q_ready = 1'b0;

        //          rst rrq rid  mv dtag  rdy   ev eid edt   full idle
        vq.push_back(mk(0, 0, 0,   0, 8'h00, 0,  0, 0, 8'h00, 0, 1));
        // two IDs, two lines, consumer ready
        vq.push_back(mk(1, 1, 3,   0, 8'h00, 1,  0, 0, 8'h00, 0, 0));
        vq.push_back(mk(1, 1, 5,   0, 8'h00, 1,  0, 0, 8'h00, 0, 0));
        vq.push_back(mk(1, 0, 0,   1, 8'hA0, 1,  1, 3, 8'hA0, 0, 0));
        vq.push_back(mk(1, 0, 0,   1, 8'hB0, 1,  1, 5, 8'hB0, 0, 0));
        vq.push_back(mk(1, 0, 0,   0, 8'h00, 1,  0, 0, 8'h00, 0, 1));
        // almost-full threshold tracking
        vq.push_back(mk(1, 1, 1,   0, 8'h00, 0,  0, 0, 8'h00, 0, 0));
        vq.push_back(mk(1, 1, 2,   0, 8'h00, 0,  0, 0, 8'h00, 0, 0));
        vq.push_back(mk(1, 1, 4,   0, 8'h00, 0,  0, 0, 8'h00, 1, 0));
        vq.push_back(mk(1, 0, 0,   1, 8'h11, 0,  1, 1, 8'h11, 1, 0));
        vq.push_back(mk(1, 0, 0,   1, 8'h22, 0,  1, 1, 8'h11, 1, 0));
        vq.push_back(mk(1, 0, 0,   1, 8'h33, 0,  1, 1, 8'h11, 1, 0));
        vq.push_back(mk(1, 0, 0,   0, 8'h00, 1,  1, 2, 8'h22, 0, 0));
        // fill to 4 lines, then write and pop together
        vq.push_back(mk(1, 1, 6,   0, 8'h00, 0,  1, 2, 8'h22, 1, 0));
        vq.push_back(mk(1, 0, 0,   1, 8'h44, 0,  1, 2, 8'h22, 1, 0));
        vq.push_back(mk(1, 1, 7,   0, 8'h00, 0,  1, 2, 8'h22, 1, 0));
        vq.push_back(mk(1, 0, 0,   1, 8'h55, 0,  1, 2, 8'h22, 1, 0));
        vq.push_back(mk(1, 1, 8,   0, 8'h00, 0,  1, 2, 8'h22, 1, 0));
        vq.push_back(mk(1, 0, 0,   1, 8'h66, 1,  1, 4, 8'h33, 1, 0));
        vq.push_back(mk(1, 0, 0,   0, 8'h00, 1,  1, 6, 8'h44, 1, 0));
        vq.push_back(mk(1, 0, 0,   0, 8'h00, 1,  1, 7, 8'h55, 0, 0));
        vq.push_back(mk(1, 0, 0,   0, 8'h00, 1,  1, 8, 8'h66, 0, 0));
        vq.push_back(mk(1, 0, 0,   0, 8'h00, 1,  0, 0, 8'h00, 0, 1));
        // ID bypass with empty ID FIFO, then pop while empty
        vq.push_back(mk(1, 1, 9,   1, 8'h99, 0,  1, 9, 8'h99, 0, 0));
        vq.push_back(mk(1, 0, 0,   0, 8'h00, 1,  0, 0, 8'h00, 0, 1));
        vq.push_back(mk(1, 0, 0,   0, 8'h00, 1,  0, 0, 8'h00, 0, 1));
        // reset with 2 lines queued and 1 ID in flight
        vq.push_back(mk(1, 1, 10,  0, 8'h00, 0,  0, 0, 8'h00, 0, 0));
        vq.push_back(mk(1, 1, 11,  0, 8'h00, 0,  0, 0, 8'h00, 0, 0));
        vq.push_back(mk(1, 1, 12,  0, 8'h00, 0,  0, 0, 8'h00, 1, 0));
        vq.push_back(mk(1, 0, 0,   1, 8'hC1, 0,  1, 10, 8'hC1, 1, 0));
        vq.push_back(mk(1, 0, 0,   1, 8'hC2, 0,  1, 10, 8'hC1, 1, 0));
        vq.push_back(mk(0, 0, 0,   0, 8'h00, 0,  0, 0, 8'h00, 0, 1));
        vq.push_back(mk(1, 1, 13,  0, 8'h00, 0,  0, 0, 8'h00, 0, 0));
        vq.push_back(mk(1, 0, 0,   1, 8'hD0, 0,  1, 13, 8'hD0, 0, 0));
        vq.push_back(mk(1, 0, 0,   0, 8'h00, 1,  0, 0, 8'h00, 0, 1));

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].rrq, vq[i].rid, vq[i].mv, vq[i].dtag, vq[i].rdy);
            chk($sformatf("v%0d q_valid", i),  128'(q_valid),  128'(vq[i].e_valid));
            chk($sformatf("v%0d rqfull_1", i), 128'(rqfull_1), 128'(vq[i].e_full));
            chk($sformatf("v%0d rdq_idle", i), 128'(rdq_idle), 128'(vq[i].e_idle));
            if (vq[i].e_valid) begin
                chk($sformatf("v%0d q_id", i),   128'(q_id), 128'(vq[i].e_id));
                chk($sformatf("v%0d q_data", i), q_data,     ln(vq[i].e_dtag));
            end
`ifdef RDQ_ERR_CHK_EN
            if (!vq[i].rst) chk($sformatf("v%0d rdq_err", i), 128'(rdq_err), 128'(2'b00));
`endif
        end

        // Overflow: fifth line into a full queue is dropped, its ID consumed.
        for (int k = 1; k <= 4; k++) step(1, 1, 4'(k), 0, 8'h00, 0);
        for (int k = 1; k <= 4; k++) step(1, 0, 0, 1, 8'(k), 0);
        step(1, 1, 5, 0, 8'h00, 0);
        step(1, 0, 0, 1, 8'hEE, 0);
        chk("ovf head id", 128'(q_id), 128'(4'd1));
        chk("ovf head data", q_data, ln(8'd1));
`ifdef RDQ_ERR_CHK_EN
        chk("ovf rdq_err", 128'(rdq_err), 128'(2'b01));
`endif
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain%0d q_id", k), 128'(q_id), 128'(k));
            chk($sformatf("drain%0d q_data", k), q_data, ln(8'(k)));
            step(1, 0, 0, 0, 8'h00, 1);
        end
        chk("drain q_valid", 128'(q_valid), 128'(1'b0));
        chk("drain rdq_idle", 128'(rdq_idle), 128'(1'b1));

        // Line with no ID in flight is tagged 0.
        step(1, 0, 0, 1, 8'hF0, 0);
        chk("noid q_valid", 128'(q_valid), 128'(1'b1));
        chk("noid q_id", 128'(q_id), 128'(4'd0));
        chk("noid q_data", q_data, ln(8'hF0));
`ifdef RDQ_ERR_CHK_EN
        chk("noid rdq_err", 128'(rdq_err), 128'(2'b11));
`endif
        step(0, 0, 0, 0, 8'h00, 0);
        chk("rst q_valid", 128'(q_valid), 128'(1'b0));
        chk("rst rqfull_1", 128'(rqfull_1), 128'(1'b0));
        chk("rst rdq_idle", 128'(rdq_idle), 128'(1'b1));
`ifdef RDQ_ERR_CHK_EN
        chk("rst rdq_err", 128'(rdq_err), 128'(2'b00));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
